uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 32, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_b  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port tx_data_i  input  8  byte to enqueue.
REQ-006 SHALL have port tx_valid_i  input  1  producer offers tx_data_i this cycle.
REQ-007 SHALL have port tx_ready_o  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port UART_TX_o  output  1  serial line; idles high.
REQ-009 SHALL have port busy_o  output  1  a frame is on the line.
REQ-010 SHALL have port fifo_count_o  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-011 Push SHALL occur on a rising edge where tx_valid_i && tx_ready_o; tx_data_i is written at the write pointer, which then advances modulo FIFO_DEPTH.
REQ-012 tx_ready_o SHALL be combinational: (fifo_count_o != FIFO_DEPTH). There is no same-cycle bypass when full, even if a pop occurs that cycle.
REQ-013 Simultaneous push and pop SHALL leave fifo_count_o unchanged; push-only adds 1; pop-only subtracts 1.
REQ-014 The FSM SHALL have four states: IDLE, START, DATA, STOP. busy_o SHALL be (state != IDLE).
REQ-015 In IDLE with fifo_count_o > 0, the next edge SHALL pop the head byte into the shift register, enter START and drive UART_TX_o low.
REQ-016 A byte pushed into an empty FIFO at edge E in IDLE SHALL produce the start-bit falling edge at edge E+1.
REQ-017 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter cleared on every state or bit change.
REQ-018 START SHALL drive 0 for one bit time, then enter DATA.
REQ-019 DATA SHALL send 8 bits LSB first using a 3-bit index, then enter STOP after bit 7.
REQ-020 STOP SHALL drive 1 for one bit time. A full frame SHALL last 10*CLKS_PER_BIT cycles.
REQ-021 At the end of STOP with the FIFO non-empty, the FSM SHALL pop and enter START on the same edge, with no idle cycle between frames.
REQ-022 At the end of STOP with the FIFO empty, the FSM SHALL enter IDLE with UART_TX_o = 1.
REQ-023 UART_TX_o SHALL be driven directly by a flop, with no combinational path to the pin.
REQ-024 A push in the same edge as the pop from an empty FIFO SHALL NOT occur; an empty FIFO gives no pop, and the pushed byte is popped no earlier than the next edge.
REQ-025 Bytes already popped SHALL be unaffected by later pushes. FIFO order SHALL be strictly first-in, first-out across pointer wrap-around.

Reset
REQ-026 While RST_b = 0 the block SHALL hold state = IDLE, UART_TX_o = 1, busy_o = 0, fifo_count_o = 0, both pointers = 0, bit counter = 0, bit index = 0, and tx_ready_o = 1.
REQ-027 Reset asserted mid-frame SHALL return UART_TX_o high immediately (asynchronously) and discard all queued bytes. After release, no partial frame SHALL resume.
REQ-028 FIFO storage contents SHALL need no reset; only pointers and count are reset.

Verification
REQ-029 Reset check: hold RST_b = 0 for 4 cycles, release -> UART_TX_o = 1, busy_o = 0, tx_ready_o = 1, fifo_count_o = 0 and stable for 100 cycles.
REQ-030 Single byte: push 0xA5 once at edge E -> UART_TX_o low at E+1 for 32 cycles, then bits 1,0,1,0,0,1,0,1 of 32 cycles each, then high for 32 cycles; busy_o falls at E+321.
REQ-031 Back-to-back: push 0xA5 then 0x7F on consecutive cycles -> the 0x7F start bit begins exactly 320 cycles after the 0xA5 start bit, and the total busy time is 640 cycles.
REQ-032 Full/backpressure: hold tx_valid_i = 1 with 0x01..0x06 -> 0x01 is popped, fifo_count_o reaches 4 and tx_ready_o = 0; 0x06 is accepted only on the edge after the 0x02 pop; the line carries 0x01..0x06 in order.
REQ-033 Wrap-around: push 10 distinct bytes in bursts of 3 -> serial output matches push order exactly.
REQ-034 Reset mid-frame: push 0x7F,0x55, assert RST_b = 0 during 0x7F bit 3 -> UART_TX_o = 1 within the same cycle, fifo_count_o = 0; after release the line stays high with no further frames.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a small synchronous byte FIFO.
// Frames go out back-to-back while the FIFO holds data; the line idles high.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RST_b,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          UART_TX_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [1:0]                    fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx;
  logic          push;
  logic          pop;
  logic          bit_end;
  logic          have_data;

  // Handshake: a byte transfers on any rising edge where tx_valid_i and
  // tx_ready_o are both high; ready depends only on the registered count,
  // so a full FIFO never accepts even when a pop happens on the same edge.
  assign have_data  = (count != '0);
  assign tx_ready_o = (count != FULL_CNT);
  assign push       = tx_valid_i && tx_ready_o;
  assign bit_end    = (bit_cnt == BIT_LAST);
  // Pop uses the registered count, so a byte pushed into an empty FIFO
  // is taken on the following edge at the earliest.
  assign pop        = have_data && ((state == ST_IDLE) || (state == ST_STOP && bit_end));

  assign UART_TX_o    = tx;
  assign busy_o       = (state != ST_IDLE);
  assign fifo_count_o = count;
  assign fsm_state    = state;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= tx_data_i;
    end
  end

  always_ff @(posedge CLK or negedge RST_b) begin
    if (!RST_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_b) begin
    if (!RST_b) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (have_data) begin
            state   <= ST_START;
            shift   <= mem[rd_ptr];
            tx      <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            tx      <= shift[0];
            bit_idx <= '0;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            // Chain straight into the next start bit when data is waiting.
            if (have_data) begin
              state <= ST_START;
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  a_count_bound: assert property (@(posedge CLK) disable iff (!RST_b) count <= FULL_CNT);
  a_idle_high:   assert property (@(posedge CLK) disable iff (!RST_b)
                                  (state == ST_IDLE || state == ST_STOP) |-> tx);
  a_start_low:   assert property (@(posedge CLK) disable iff (!RST_b) (state == ST_START) |-> !tx);

endmodule
